// File: rtl/vreg_pkg.sv
// rtl/vreg_pkg.sv - shared types, defaults and helpers for the vector register file
package vreg_pkg;

    localparam int DATA_W_DEFAULT = 512;

    typedef enum logic {
        SB_IDLE,
        SB_PENDING
    } sb_state_t;

    // A pair always starts on an even register: drop the address lsb.
    function automatic int unsigned pair_base(input int unsigned addr);
        return addr & ~32'd1;
    endfunction

endpackage

// File: rtl/vreg_scoreboard.sv
// rtl/vreg_scoreboard.sv - one-entry pair reservation tracker with hazard detection
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   we, waddr           scalar write request (checked for WAW hazards only)
//   pw_issue, pw_dst    reserve the pair {pw_dst[msb:1], 0} / +1
//   pw_valid            pair result arrives this cycle
//   busy                per-register reservation bits (registered)
//   pw_pending          a reservation is outstanding (registered)
//   pair_wr             pair write strobe for this cycle
//   pair_lo_addr        latched even address of the pair being written
//   pair_hi_addr        latched odd address of the pair being written
//   err                 protocol-error pulse for this cycle
module vreg_scoreboard
    import vreg_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic                pw_issue,
    input  logic [ADDR_W-1:0]   pw_dst,
    input  logic                pw_valid,
    output logic [NUM_REGS-1:0] busy,
    output logic                pw_pending,
    output logic                pair_wr,
    output logic [ADDR_W-1:0]   pair_lo_addr,
    output logic [ADDR_W-1:0]   pair_hi_addr,
    output logic                err
);

    sb_state_t             state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [ADDR_W-1:0]     new_lo, new_hi;

    assign new_lo       = ADDR_W'(pair_base(32'(pw_dst)));
    assign new_hi       = {new_lo[ADDR_W-1:1], 1'b1};
    assign pair_lo_addr = base_q;
    assign pair_hi_addr = {base_q[ADDR_W-1:1], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SB_IDLE;
            base_q  <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        busy_d  = busy_q;
        pair_wr = 1'b0;
        err     = 1'b0;

        // A scalar write into a reserved register is a WAW hazard. This also
        // covers a scalar write colliding with the pair write-back, since the
        // write-back only targets reserved registers.
        if (we && busy_q[waddr]) begin
            err = 1'b1;
        end

        case (state_q)
            SB_IDLE: begin
                if (pw_valid) begin
                    err = 1'b1;
                end
                if (pw_issue) begin
                    state_d        = SB_PENDING;
                    base_d         = new_lo;
                    busy_d[new_lo] = 1'b1;
                    busy_d[new_hi] = 1'b1;
                end
            end
            SB_PENDING: begin
                if (pw_valid) begin
                    pair_wr              = 1'b1;
                    busy_d[pair_lo_addr] = 1'b0;
                    busy_d[pair_hi_addr] = 1'b0;
                    // Re-reserve after clearing so re-issuing the same pair
                    // leaves its busy bits set.
                    if (pw_issue) begin
                        base_d         = new_lo;
                        busy_d[new_lo] = 1'b1;
                        busy_d[new_hi] = 1'b1;
                    end else begin
                        state_d = SB_IDLE;
                    end
                end else if (pw_issue) begin
                    err = 1'b1;
                end
            end
        endcase
    end

    assign busy       = busy_q;
    assign pw_pending = (state_q == SB_PENDING);

endmodule

// File: rtl/vreg_file_sb.sv
// rtl/vreg_file_sb.sv - vector register file with pair write-back scoreboard
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   re_a/raddr_a/rdata_a/busy_a  read port A: enable, address, registered data,
//                                combinational busy (read suppressed)
//   re_b/raddr_b/rdata_b/busy_b  read port B, same as port A
//   we/waddr/wdata               scalar write port
//   pw_issue/pw_dst              reserve a register pair
//   pw_valid/pw_lo/pw_hi         pair result write-back
//   pw_pending                   a pair reservation is outstanding
//   err_sticky                   sticky protocol-error flag
module vreg_file_sb
    import vreg_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEFAULT,
    parameter  int NUM_REGS = 8,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              busy_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pw_issue,
    input  logic [ADDR_W-1:0] pw_dst,
    input  logic              pw_valid,
    input  logic [DATA_W-1:0] pw_lo,
    input  logic [DATA_W-1:0] pw_hi,
    output logic              pw_pending,
    output logic              err_sticky
);

    logic [DATA_W-1:0]   regs      [NUM_REGS];
    logic [DATA_W-1:0]   regs_next [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                pair_wr;
    logic [ADDR_W-1:0]   pair_lo_addr;
    logic [ADDR_W-1:0]   pair_hi_addr;
    logic                sb_err;

    vreg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .we           (we),
        .waddr        (waddr),
        .pw_issue     (pw_issue),
        .pw_dst       (pw_dst),
        .pw_valid     (pw_valid),
        .busy         (busy),
        .pw_pending   (pw_pending),
        .pair_wr      (pair_wr),
        .pair_lo_addr (pair_lo_addr),
        .pair_hi_addr (pair_hi_addr),
        .err          (sb_err)
    );

    assign busy_a = re_a & busy[raddr_a];
    assign busy_b = re_b & busy[raddr_b];

    // Post-write register image; reads sample it so same-edge writes bypass.
    // Pair write-back wins over a scalar write; scalar writes to reserved
    // registers are dropped.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_next[i] = regs[i];
            if (pair_wr && (ADDR_W'(i) == pair_lo_addr)) begin
                regs_next[i] = pw_lo;
            end else if (pair_wr && (ADDR_W'(i) == pair_hi_addr)) begin
                regs_next[i] = pw_hi;
            end else if (we && !busy[i] && (ADDR_W'(i) == waddr)) begin
                regs_next[i] = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            rdata_a    <= '0;
            rdata_b    <= '0;
            err_sticky <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= regs_next[i];
            end
            if (re_a && !busy_a) begin
                rdata_a <= regs_next[raddr_a];
            end
            if (re_b && !busy_b) begin
                rdata_b <= regs_next[raddr_b];
            end
            if (sb_err) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vreg_file_sb.sv
// tb/tb_vreg_file_sb.sv - scoreboard testbench for vreg_file_sb
module tb_vreg_file_sb;

    localparam int DW = 512;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          re_a, re_b, we, pw_issue, pw_valid;
    logic [AW-1:0] raddr_a, raddr_b, waddr, pw_dst;
    logic [DW-1:0] rdata_a, rdata_b, wdata, pw_lo, pw_hi;
    logic          busy_a, busy_b, pw_pending, err_sticky;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] qa[$];
    string         na[$];
    logic [DW-1:0] qb[$];
    string         nb[$];

    always #5 clk = ~clk;

    vreg_file_sb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .re_a       (re_a),
        .raddr_a    (raddr_a),
        .rdata_a    (rdata_a),
        .busy_a     (busy_a),
        .re_b       (re_b),
        .raddr_b    (raddr_b),
        .rdata_b    (rdata_b),
        .busy_b     (busy_b),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .pw_issue   (pw_issue),
        .pw_dst     (pw_dst),
        .pw_valid   (pw_valid),
        .pw_lo      (pw_lo),
        .pw_hi      (pw_hi),
        .pw_pending (pw_pending),
        .err_sticky (err_sticky)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic exp_a(input string name, input logic [DW-1:0] v);
        qa.push_back(v);
        na.push_back(name);
    endtask

    task automatic exp_b(input string name, input logic [DW-1:0] v);
        qb.push_back(v);
        nb.push_back(name);
    endtask

    task automatic next();
        @(negedge clk);
        re_a = 0; re_b = 0; we = 0; pw_issue = 0; pw_valid = 0;
    endtask

    // Monitor: a read fires when enabled and not busy just before the edge;
    // its data is popped from the scoreboard and compared after the edge.
    logic fa, fb;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            fa = re_a && !busy_a;
            fb = re_b && !busy_b;
            @(posedge clk);
            #1;
            if (fa) begin
                if (qa.size() == 0) chk("unexpected_read_a", rdata_a, 'x);
                else chk(na.pop_front(), rdata_a, qa.pop_front());
            end
            if (fb) begin
                if (qb.size() == 0) chk("unexpected_read_b", rdata_b, 'x);
                else chk(nb.pop_front(), rdata_b, qb.pop_front());
            end
        end
    end

    initial begin
        rst_n = 0;
        re_a = 0; re_b = 0; we = 0; pw_issue = 0; pw_valid = 0;
        raddr_a = 0; raddr_b = 0; waddr = 0; pw_dst = 0;
        wdata = 0; pw_lo = 0; pw_hi = 0;
        repeat (2) @(negedge clk);
        chk("rst_rdata_a", rdata_a, 0);
        chk("rst_rdata_b", rdata_b, 0);
        chk("rst_pending", 512'(pw_pending), 0);
        chk("rst_err", 512'(err_sticky), 0);
        rst_n = 1;

        // All registers read back zero after reset.
        for (int i = 0; i < 8; i++) begin
            next();
            re_a = 1; raddr_a = AW'(i);
            exp_a($sformatf("reset_r%0d", i), 0);
        end

        // Scalar write with same-edge read bypass.
        next();
        we = 1; waddr = 3; wdata = 512'hA5;
        re_a = 1; raddr_a = 3;
        exp_a("bypass_we_r3", 512'hA5);
        #1 chk("bypass_busy_a", 512'(busy_a), 0);
        next();
        re_b = 1; raddr_b = 3;
        exp_b("read_b_r3", 512'hA5);

        // Reserve r4/r5 with an odd pw_dst.
        next();
        pw_issue = 1; pw_dst = 5;
        next();
        chk("issue_pending", 512'(pw_pending), 1);
        re_b = 1; raddr_b = 5;
        #1 chk("busy_b_r5", 512'(busy_b), 1);
        next();
        chk("rdata_b_held", rdata_b, 512'hA5);
        re_a = 1; raddr_a = 4;
        #1 chk("busy_a_r4", 512'(busy_a), 1);
        next();
        pw_valid = 1; pw_lo = 1; pw_hi = 2; pw_dst = 0;
        re_a = 1; raddr_a = 4;
        #1 chk("busy_a_r4_during_valid", 512'(busy_a), 1);
        next();
        chk("retire_pending", 512'(pw_pending), 0);
        re_b = 1; raddr_b = 5;
        exp_b("pair_hi_r5", 512'h2);
        next();
        re_a = 1; raddr_a = 4;
        exp_a("pair_lo_r4", 512'h1);

        // Back-to-back retire and re-issue: r0/r1 retire, r6/r7 reserved.
        next();
        pw_issue = 1; pw_dst = 0;
        next();
        pw_valid = 1; pw_lo = 512'hAA; pw_hi = 512'hBB;
        pw_issue = 1; pw_dst = 6;
        re_a = 1; raddr_a = 0;
        #1 chk("swap_busy_a_r0", 512'(busy_a), 1);
        next();
        chk("swap_pending", 512'(pw_pending), 1);
        chk("swap_err", 512'(err_sticky), 0);
        re_a = 1; raddr_a = 1;
        exp_a("swap_r1", 512'hBB);
        re_b = 1; raddr_b = 7;
        #1 chk("swap_busy_b_r7", 512'(busy_b), 1);
        next();
        pw_valid = 1; pw_lo = 512'hC6; pw_hi = 512'hC7;
        re_b = 1; raddr_b = 0;
        exp_b("swap_r0", 512'hAA);
        next();
        re_a = 1; raddr_a = 6;
        exp_a("pair_r6", 512'hC6);
        re_b = 1; raddr_b = 7;
        exp_b("pair_r7", 512'hC7);

        // WAW hazard and ignored re-issue while pending on r2/r3.
        next();
        pw_issue = 1; pw_dst = 2;
        next();
        we = 1; waddr = 3; wdata = 512'h77;
        next();
        chk("waw_err", 512'(err_sticky), 1);
        pw_issue = 1; pw_dst = 0;
        next();
        chk("reissue_pending", 512'(pw_pending), 1);
        re_a = 1; raddr_a = 0;
        #1 chk("reissue_r0_not_busy", 512'(busy_a), 0);
        exp_a("reissue_r0", 512'hAA);
        next();
        pw_valid = 1; pw_lo = 512'h10; pw_hi = 512'h11;
        next();
        re_a = 1; raddr_a = 3;
        exp_a("waw_dropped_r3", 512'h11);
        re_b = 1; raddr_b = 2;
        exp_b("waw_r2", 512'h10);

        // Reset while pending, then a spurious pw_valid.
        next();
        pw_issue = 1; pw_dst = 2;
        next();
        chk("pre_rst_pending", 512'(pw_pending), 1);
        rst_n = 0;
        #2;
        chk("mid_rst_pending", 512'(pw_pending), 0);
        chk("mid_rst_err", 512'(err_sticky), 0);
        next();
        rst_n = 1;
        next();
        pw_valid = 1; pw_lo = 512'h5; pw_hi = 512'h6;
        next();
        chk("spurious_err", 512'(err_sticky), 1);
        chk("spurious_pending", 512'(pw_pending), 0);
        for (int i = 0; i < 8; i++) begin
            re_a = 1; raddr_a = AW'(i);
            exp_a($sformatf("post_rst_r%0d", i), 0);
            next();
        end

        repeat (3) next();
        chk("drain_qa", 512'(qa.size()), 0);
        chk("drain_qb", 512'(qb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vreg_file_sb.md
Name: vreg_file_sb

Overview:
- Parametrised successor to the 4 x 512-bit register file.
- Holds NUM_REGS vector registers with two registered read ports and one scalar write port.
- Has a dedicated pair write-back port: multiplier low half to an even register, high half to the next odd register.
- A one-entry scoreboard tracks the pending pair, flags hazards to the issuing controller and bypasses same-cycle writes to readers.

Parameters:
- DATA_W, 512, register width in bits.
- NUM_REGS, 8, number of registers; power of two, at least 4.
- ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- re_a  in  1  read enable, port A.
- raddr_a  in  ADDR_W  read address, port A.
- rdata_a  out  DATA_W  registered read data, port A.
- busy_a  out  1  port A read targets a busy register; read suppressed.
- re_b, raddr_b, rdata_b, busy_b: same as the port A signals, for port B.
- we  in  1  scalar write enable.
- waddr  in  ADDR_W  scalar write address.
- wdata  in  DATA_W  scalar write data.
- pw_issue  in  1  reserve a register pair for a long-latency result.
- pw_dst  in  ADDR_W  pair base address; lsb ignored and forced to 0.
- pw_valid  in  1  pair result valid this cycle.
- pw_lo, pw_hi  in  DATA_W  low and high result halves.
- pw_pending  out  1  a pair reservation is outstanding.
- err_sticky  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset is asynchronous on rst_n low. It clears all registers, rdata_a and rdata_b, the busy bits, pw_pending and err_sticky to 0.
- A reset mid-operation discards the outstanding reservation. A later pw_valid is then treated as spurious.
- Reads: 1-cycle latency. If re_x is high and busy_x is low at edge N, rdata_x equals the register contents after N's writes are applied.
  - This gives a write-to-read bypass: a we or pw_valid to the same address at edge N is visible on rdata_x after N.
  - rdata_x holds its previous value when re_x is low or busy_x is high.
- busy_x is combinational: re_x AND busy[raddr_x]. The consumer retries; the block does not queue reads.
- Scalar write: when we is high at the edge, reg[waddr] <= wdata, unless one of these applies:
  - waddr is busy: the write is dropped and err_sticky is set (WAW hazard).
  - pw_valid targets waddr in the same cycle: the pair write wins and err_sticky is set.
- Scoreboard, one outstanding pair at most. Its states are IDLE and PENDING.
  - IDLE to PENDING: on pw_issue. Sets busy[d] and busy[d+1], where d = {pw_dst[ADDR_W-1:1], 1'b0}, and latches d.
  - PENDING to IDLE: on pw_valid. Writes reg[d] <= pw_lo and reg[d+1] <= pw_hi using the latched d, and clears both busy bits.
  - PENDING, pw_issue with no pw_valid: the issue is ignored and err_sticky is set.
  - PENDING, pw_issue and pw_valid in the same cycle: the old pair retires, the new pair is reserved, and the state stays PENDING.
    - If the new pair equals the old pair, its busy bits end set.
  - IDLE, pw_valid: ignored, no register write, err_sticky set.
- pw_pending is high exactly in the PENDING state.
- The write-back data uses the latched d; pw_dst is ignored during pw_valid.
- Outputs are glitch-free registered values, except busy_a and busy_b.

Decomposition:
- Shared package vreg_pkg holds:
  - the DATA_W default (512);
  - the pair-base helper function that clears the address lsb;
  - the scoreboard state enum {SB_IDLE, SB_PENDING}.
- Sub-module vreg_scoreboard holds the busy bit vector, the latched pair base, the state register and the error detection.
  - It exports busy[NUM_REGS-1:0], pw_pending, the pair-write strobe with its address, and the error pulse.
- The top level holds storage, the read ports, the bypass and the err_sticky register.

Test Plan:
- Reset, then re_a to r0..r7 on successive cycles -> each rdata_a is 0 one cycle later; pw_pending = 0; err_sticky = 0.
- we to r3 with wdata = 0xA5 (zero-extended) and re_a to r3 at the same edge -> rdata_a = 0xA5 after that edge; busy_a stays 0.
- pw_issue with pw_dst = 5 -> r4 and r5 busy; re_b to r5 gives busy_b = 1 and rdata_b unchanged.
  - Three cycles later, pw_valid with lo = 1, hi = 2 -> r4 = 1, r5 = 2, pw_pending = 0, and re_b to r5 then returns 2.
- While PENDING on r2/r3: we to r3 -> write dropped, err_sticky = 1. A second pw_issue -> ignored, pw_pending stays 1.
- pw_valid and pw_issue for r6 in the same cycle while PENDING on r0 -> r0/r1 written, r6/r7 become busy, pw_pending stays 1, err_sticky stays 0.
- rst_n pulsed low mid-PENDING, then pw_valid -> no register write, err_sticky = 1, all registers still 0.
